// File: rtl/dvi_tmds_decoder_if.sv
// -----------------------------------------------------------------------------
// dvi_tmds_decoder_if
// Bundles the TMDS word inputs and the decoded pixel/raster outputs of
// dvi_tmds_decoder.
//   tmds0/1/2_10bit : word-aligned 10-bit TMDS words, one per channel per clock
//   rgb, de, hsync, vsync, cx, cy : decoded pixel stream and coordinates
//   locked, token_err             : raster lock status and token error pulse
//   lock_state                    : lock FSM state (0=SEARCH 1=CHECK 2=LOCKED)
// Stream semantics: there is no valid/ready pair. The source (master) presents
// one new word per channel on every clk_pixel cycle and the decoder (slave)
// accepts it unconditionally; outputs carry one decoded word per cycle, two
// cycles after the corresponding input, with no back-pressure.
// -----------------------------------------------------------------------------
interface dvi_tmds_decoder_if #(
  parameter int BIT_WIDTH  = 12,
  parameter int BIT_HEIGHT = 11
);
  logic [9:0]            tmds0_10bit;
  logic [9:0]            tmds1_10bit;
  logic [9:0]            tmds2_10bit;
  logic [23:0]           rgb;
  logic                  de;
  logic                  hsync;
  logic                  vsync;
  logic [BIT_WIDTH-1:0]  cx;
  logic [BIT_HEIGHT-1:0] cy;
  logic                  locked;
  logic                  token_err;
  logic [1:0]            lock_state;

  modport master (
    output tmds0_10bit, tmds1_10bit, tmds2_10bit,
    input  rgb, de, hsync, vsync, cx, cy, locked, token_err, lock_state
  );

  modport slave (
    input  tmds0_10bit, tmds1_10bit, tmds2_10bit,
    output rgb, de, hsync, vsync, cx, cy, locked, token_err, lock_state
  );
endinterface

// File: rtl/dvi_tmds_decoder.sv
// -----------------------------------------------------------------------------
// dvi_tmds_decoder
// Decodes three word-aligned TMDS channels into 24-bit RGB plus DE/HSYNC/VSYNC,
// rebuilds active pixel coordinates and locks onto a raster of the configured
// geometry (SCREEN_WIDTH x SCREEN_HEIGHT active, FRAME_WIDTH clocks per line).
// Ports:
//   clk_pixel        : pixel clock, one word per channel per cycle
//   clk_pixel_resetn : asynchronous active-low reset
//   bus (slave)      : tmds words in; rgb/de/hsync/vsync/cx/cy/locked/
//                      token_err/lock_state out (see dvi_tmds_decoder_if)
// Pipeline: stage 1 registers raw words, stage 2 registers decoded outputs,
// giving a fixed 2-cycle latency. locked is derived from the FSM register,
// which updates on the same edge as stage 2.
// -----------------------------------------------------------------------------
module dvi_tmds_decoder #(
  parameter int SCREEN_WIDTH  = 1024,
  parameter int SCREEN_HEIGHT = 768,
  parameter int FRAME_WIDTH   = 1376,
  parameter int BIT_WIDTH     = 12,
  parameter int BIT_HEIGHT    = 11,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic               clk_pixel,
  input  logic               clk_pixel_resetn,
  dvi_tmds_decoder_if.slave  bus
);
  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;
  localparam int         CW     = 16;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} lock_state_t;

  function automatic logic is_ctl(input logic [9:0] q);
    return (q == TOK_00) || (q == TOK_01) || (q == TOK_10) || (q == TOK_11);
  endfunction

  // Returns {C1,C0}; only meaningful when is_ctl(q).
  function automatic logic [1:0] ctl_bits(input logic [9:0] q);
    logic [1:0] c;
    case (q)
      TOK_01:  c = 2'b01;
      TOK_10:  c = 2'b10;
      TOK_11:  c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] tmds_dec(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    d    = q[9] ? ~q[7:0] : q[7:0];
    o    = '0;
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  // Stage 1
  logic [9:0] w0_q, w1_q, w2_q;
  logic       v1_q;  // stage 1 holds a real word (false only right after reset)

  // Stage 2 / outputs
  logic [23:0]           rgb_q;
  logic                  de_q, hs_q, vs_q, terr_q;
  logic [BIT_WIDTH-1:0]  cx_q;
  logic [BIT_HEIGHT-1:0] cy_q;
  logic                  cy_pend_q;   // next DE rise is the first line of a frame

  // Raster measurement
  logic [CW-1:0] run_q, per_q, line_q;
  logic          first_line_q;        // period check skipped on this line
  lock_state_t   state, state_n;
  logic [3:0]    good_q, good_n;

  // Classification of the stage-1 words
  logic       ctl0, ctl1, ctl2, err_c, de_c, hs_c, vs_c;
  logic       de_rise, de_fall, vs_fall, line_bad, frame_bad, fail;

  assign ctl0  = is_ctl(w0_q);
  assign ctl1  = is_ctl(w1_q);
  assign ctl2  = is_ctl(w2_q);
  assign err_c = ctl0 ? ((w1_q != TOK_00) || (w2_q != TOK_00)) : (ctl1 || ctl2);
  assign de_c  = !ctl0;
  // Sync levels change only on control words and hold through active video.
  assign hs_c  = ctl0 ? ctl_bits(w0_q)[0] : hs_q;
  assign vs_c  = ctl0 ? ctl_bits(w0_q)[1] : vs_q;

  assign de_rise = v1_q && de_c && !de_q;
  assign de_fall = v1_q && !de_c && de_q;
  assign vs_fall = v1_q && vs_q && !vs_c;

  assign line_bad  = (de_fall && (run_q != CW'(SCREEN_WIDTH))) ||
                     (de_rise && !first_line_q && (per_q != CW'(FRAME_WIDTH)));
  assign frame_bad = vs_fall && (line_q != CW'(SCREEN_HEIGHT));
  assign fail      = (v1_q && err_c) || line_bad || frame_bad;

  always_ff @(posedge clk_pixel or negedge clk_pixel_resetn) begin
    if (!clk_pixel_resetn) begin
      w0_q <= '0;
      w1_q <= '0;
      w2_q <= '0;
      v1_q <= 1'b0;
    end else begin
      w0_q <= bus.tmds0_10bit;
      w1_q <= bus.tmds1_10bit;
      w2_q <= bus.tmds2_10bit;
      v1_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_pixel or negedge clk_pixel_resetn) begin
    if (!clk_pixel_resetn) begin
      rgb_q        <= '0;
      de_q         <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      terr_q       <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
      cy_pend_q    <= 1'b0;
      run_q        <= '0;
      per_q        <= '0;
      line_q       <= '0;
      first_line_q <= 1'b0;
    end else if (v1_q) begin
      de_q   <= de_c;
      hs_q   <= hs_c;
      vs_q   <= vs_c;
      terr_q <= err_c;
      if (de_c) begin
        rgb_q <= {tmds_dec(w0_q), tmds_dec(w1_q), tmds_dec(w2_q)};
        cx_q  <= de_q ? cx_q + 1'b1 : '0;
      end
      if (de_rise) begin
        cy_q      <= cy_pend_q ? '0 : cy_q + 1'b1;
        cy_pend_q <= 1'b0;
      end else if (vs_fall) begin
        cy_pend_q <= 1'b1;
      end
      // Run length of the current DE-high stretch, saturating.
      if (de_rise)                         run_q <= CW'(1);
      else if (de_c && (run_q != CNT_MAX)) run_q <= run_q + 1'b1;
      // Clocks since the last DE rise, saturating.
      if (de_rise)                per_q <= CW'(1);
      else if (per_q != CNT_MAX)  per_q <= per_q + 1'b1;
      // Active lines since the last vsync falling edge, saturating.
      if (vs_fall)                           line_q <= '0;
      else if (de_rise && (line_q != CNT_MAX)) line_q <= line_q + 1'b1;
      if (vs_fall)      first_line_q <= 1'b1;
      else if (de_rise) first_line_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_pixel or negedge clk_pixel_resetn) begin
    if (!clk_pixel_resetn) begin
      state  <= SEARCH;
      good_q <= '0;
    end else begin
      state  <= state_n;
      good_q <= good_n;
    end
  end

  // A failure in the same word as a vsync falling edge takes priority, so a
  // frame that ends on a bad word never counts as good.
  always_comb begin
    state_n = state;
    good_n  = good_q;
    unique case (state)
      SEARCH: begin
        good_n = '0;
        if (vs_fall) state_n = CHECK;
      end
      CHECK, LOCKED: begin
        if (fail) begin
          state_n = SEARCH;
          good_n  = '0;
        end else if (vs_fall) begin
          if (good_q != 4'(LOCK_FRAMES)) good_n = good_q + 4'd1;
          if ((state == CHECK) && (good_n == 4'(LOCK_FRAMES))) state_n = LOCKED;
        end
      end
      default: begin
        state_n = SEARCH;
        good_n  = '0;
      end
    endcase
  end

  assign bus.rgb        = rgb_q;
  assign bus.de         = de_q;
  assign bus.hsync      = hs_q;
  assign bus.vsync      = vs_q;
  assign bus.cx         = cx_q;
  assign bus.cy         = cy_q;
  assign bus.token_err  = terr_q;
  assign bus.locked     = (state == LOCKED);
  assign bus.lock_state = state;
endmodule

// File: tb/tb_dvi_tmds_decoder.sv
// -----------------------------------------------------------------------------
// tb_dvi_tmds_decoder
// Drives dvi_tmds_decoder with directed words and a scaled raster generator
// (16 active of 24 clocks per line, 6 active of 10 lines per frame). Every
// driven word pushes its expected output into exp_q; the entry is popped and
// compared once the 2-cycle pipeline delivers it.
// -----------------------------------------------------------------------------
module tb_dvi_tmds_decoder;
  localparam int W      = 16;
  localparam int H_TOT  = 24;
  localparam int V_ACT  = 6;
  localparam int V_TOT  = 10;
  localparam int HS0    = 18;
  localparam int HS1    = 20;
  localparam int VS0    = 7;
  localparam int VS1    = 8;
  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  typedef struct packed {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        terr;
    logic        lk;
    logic [11:0] cx;
    logic [10:0] cy;
    logic        chk_cx;
    logic        chk_cy;
  } exp_t;

  // Clock / reset
  logic clk_pixel = 1'b0;
  logic clk_pixel_resetn;
  always #5 clk_pixel = ~clk_pixel;

  dvi_tmds_decoder_if #(.BIT_WIDTH(12), .BIT_HEIGHT(11)) bus ();

  dvi_tmds_decoder #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(V_ACT), .FRAME_WIDTH(H_TOT),
    .BIT_WIDTH(12), .BIT_HEIGHT(11), .LOCK_FRAMES(2)
  ) dut (
    .clk_pixel        (clk_pixel),
    .clk_pixel_resetn (clk_pixel_resetn),
    .bus              (bus)
  );

  // Scoreboard state
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [23:0] h_rgb;
  logic        h_hs, h_vs, exp_lk, cy_armed, cy_valid;
  logic [11:0] h_cx;
  logic [10:0] h_cy;

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b01:   return T01;
      2'b10:   return T10;
      2'b11:   return T11;
      default: return T00;
    endcase
  endfunction

  // Transition-minimising TMDS encoder; inv selects the optional inversion.
  function automatic logic [9:0] enc(input logic [7:0] d, input logic inv);
    int         n1;
    logic       xn;
    logic [8:0] qm;
    n1    = $countones(d);
    xn    = (n1 > 4) || ((n1 == 4) && !d[0]);
    qm    = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  function automatic exp_t mk(input logic [23:0] rgb, input logic de, input logic hs,
                              input logic vs, input logic terr, input logic [11:0] cx,
                              input logic [10:0] cy, input logic chk_cx, input logic chk_cy);
    exp_t e;
    e.rgb = rgb; e.de = de; e.hs = hs; e.vs = vs; e.terr = terr; e.lk = exp_lk;
    e.cx = cx; e.cy = cy; e.chk_cx = chk_cx; e.chk_cy = chk_cy;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic compare(input exp_t e);
    chk("rgb", 32'(bus.rgb), 32'(e.rgb));
    chk("de", 32'(bus.de), 32'(e.de));
    chk("hsync", 32'(bus.hsync), 32'(e.hs));
    chk("vsync", 32'(bus.vsync), 32'(e.vs));
    chk("token_err", 32'(bus.token_err), 32'(e.terr));
    chk("locked", 32'(bus.locked), 32'(e.lk));
    if (e.chk_cx) chk("cx", 32'(bus.cx), 32'(e.cx));
    if (e.chk_cy) chk("cy", 32'(bus.cy), 32'(e.cy));
  endtask

  // Driver: present one word per channel for one cycle.
  task automatic step(input logic [9:0] w0, input logic [9:0] w1, input logic [9:0] w2,
                      input exp_t e);
    bus.tmds0_10bit = w0;
    bus.tmds1_10bit = w1;
    bus.tmds2_10bit = w2;
    exp_q.push_back(e);
    @(posedge clk_pixel); #1;
    if (exp_q.size() >= 2) compare(exp_q.pop_front());
  endtask

  task automatic flush();
    while (exp_q.size() > 0) begin
      @(posedge clk_pixel); #1;
      compare(exp_q.pop_front());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rgb"}, 32'(bus.rgb), 32'h0);
    chk({tag, "_de"}, 32'(bus.de), 32'h0);
    chk({tag, "_hsync"}, 32'(bus.hsync), 32'h0);
    chk({tag, "_vsync"}, 32'(bus.vsync), 32'h0);
    chk({tag, "_cx"}, 32'(bus.cx), 32'h0);
    chk({tag, "_cy"}, 32'(bus.cy), 32'h0);
    chk({tag, "_locked"}, 32'(bus.locked), 32'h0);
    chk({tag, "_token_err"}, 32'(bus.token_err), 32'h0);
    chk({tag, "_state"}, 32'(bus.lock_state), 32'h0);
  endtask

  // One frame of the scaled raster. bad_line shortens that active line by
  // one word; lock_rise marks the frame whose vsync falling edge locks.
  task automatic gen_frame(input int bad_line, input bit lock_rise);
    logic [23:0] pix;
    logic [9:0]  w0, w1, w2;
    logic        hs, vs;
    exp_t        e;
    for (int y = 0; y < V_TOT; y++) begin
      for (int x = 0; x < H_TOT; x++) begin
        if ((y < V_ACT) && (x < W) && !((y == bad_line) && (x == W - 1))) begin
          pix = 24'($urandom);
          w0  = enc(pix[23:16], 1'($urandom_range(0, 1)));
          w1  = enc(pix[15:8], 1'($urandom_range(0, 1)));
          w2  = enc(pix[7:0], 1'($urandom_range(0, 1)));
          h_rgb = pix;
          h_cx  = 12'(x);
          h_cy  = 11'(y);
          if (cy_armed) begin
            cy_valid = 1'b1;
            cy_armed = 1'b0;
          end
          e = mk(h_rgb, 1'b1, h_hs, h_vs, 1'b0, h_cx, h_cy, 1'b1, cy_valid);
        end else begin
          hs = (x >= HS0) && (x <= HS1);
          vs = (y >= VS0) && (y <= VS1);
          if (h_vs && !vs) begin
            cy_armed = 1'b1;
            if (lock_rise) exp_lk = 1'b1;
          end
          if ((y == bad_line) && (x == W - 1)) exp_lk = 1'b0;
          w0 = tok({vs, hs});
          w1 = T00;
          w2 = T00;
          h_hs = hs;
          h_vs = vs;
          e = mk(h_rgb, 1'b0, h_hs, h_vs, 1'b0, h_cx, h_cy, 1'b1, cy_valid);
        end
        step(w0, w1, w2, e);
      end
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    h_rgb = '0; h_hs = 1'b0; h_vs = 1'b0; h_cx = '0; h_cy = '0;
    exp_lk = 1'b0; cy_armed = 1'b0; cy_valid = 1'b0;
  endtask

  initial begin
    clear_model();
    bus.tmds0_10bit  = T00;
    bus.tmds1_10bit  = T00;
    bus.tmds2_10bit  = T00;
    clk_pixel_resetn = 1'b1;
    #2 clk_pixel_resetn = 1'b0;
    repeat (3) @(posedge clk_pixel);
    #1 check_reset_outputs("reset");
    @(negedge clk_pixel) clk_pixel_resetn = 1'b1;

    // Directed decode and control words.
    step(10'h100, 10'h3FF, 10'h200, mk(24'h0000FF, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 11'd0, 1'b1, 1'b0));
    step(enc(8'h12, 1'b1), enc(8'h34, 1'b0), enc(8'h56, 1'b1),
         mk(24'h123456, 1'b1, 1'b0, 1'b0, 1'b0, 12'd1, 11'd0, 1'b1, 1'b0));
    step(T00, T00, T00, mk(24'h123456, 1'b0, 1'b0, 1'b0, 1'b0, 12'd1, 11'd0, 1'b1, 1'b0));
    step(T11, T00, T00, mk(24'h123456, 1'b0, 1'b1, 1'b1, 1'b0, 12'd1, 11'd0, 1'b1, 1'b0));
    step(T01, T00, T00, mk(24'h123456, 1'b0, 1'b1, 1'b0, 1'b0, 12'd1, 11'd0, 1'b1, 1'b0));
    step(T10, T00, T00, mk(24'h123456, 1'b0, 1'b0, 1'b1, 1'b0, 12'd1, 11'd0, 1'b1, 1'b0));
    step(T11, T00, T00, mk(24'h123456, 1'b0, 1'b1, 1'b1, 1'b0, 12'd1, 11'd0, 1'b1, 1'b0));
    step(enc(8'hA5, 1'b0), enc(8'h00, 1'b1), enc(8'hFF, 1'b0),
         mk(24'hA500FF, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 11'd0, 1'b1, 1'b0));
    flush();

    // Asynchronous reset mid-stream: outputs clear before the next edge.
    #2 clk_pixel_resetn = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk_pixel) clk_pixel_resetn = 1'b1;
    clear_model();

    // Lock, loss on a short line, relock.
    gen_frame(-1, 1'b0);
    gen_frame(-1, 1'b0);
    gen_frame(-1, 1'b1);
    gen_frame(-1, 1'b0);
    gen_frame(2, 1'b0);
    gen_frame(-1, 1'b0);
    gen_frame(-1, 1'b1);

    // Control on channel 0 with data on channel 2 while locked.
    exp_lk = 1'b0;
    step(T00, T00, 10'h100, mk(h_rgb, 1'b0, 1'b0, 1'b0, 1'b1, h_cx, h_cy, 1'b1, cy_valid));
    for (int i = 0; i < 3; i++)
      step(T00, T00, T00, mk(h_rgb, 1'b0, 1'b0, 1'b0, 1'b0, h_cx, h_cy, 1'b1, cy_valid));
    flush();
    chk("state_after_err", 32'(bus.lock_state), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dvi_tmds_decoder.md
# dvi_tmds_decoder

Sink-side counterpart of the DVI output path. Accepts three word-aligned 10-bit TMDS channel words per pixel clock, decodes them to 24-bit RGB plus DE/HSYNC/VSYNC, reconstructs pixel coordinates, and checks the recovered raster against the fixed 1376x810 frame with a 1024x768 active area. Sits after the deserializer/word aligner in loopback and capture paths.

## Interface
- SCREEN_WIDTH, 1024, active pixels per line
- SCREEN_HEIGHT, 768, active lines per frame
- FRAME_WIDTH, 1376, total clocks per line, DE rise to DE rise
- BIT_WIDTH, 12, cx width
- BIT_HEIGHT, 11, cy width
- LOCK_FRAMES, 2, consecutive conforming frames required to lock (1..15)

Ports:
- clk_pixel  in  1  pixel clock; one TMDS word per channel per cycle
- clk_pixel_resetn  in  1  reset; one clock; reset is asynchronous and active-low
- tmds0_10bit  in  10  channel 0: R data, control {C1=vsync, C0=hsync}
- tmds1_10bit  in  10  channel 1: G data, control must be C1C0=00
- tmds2_10bit  in  10  channel 2: B data, control must be C1C0=00
- rgb  out  24  {R,G,B}; held at last value while de=0
- de  out  1  recovered data enable
- hsync  out  1  recovered C0 of channel 0
- vsync  out  1  recovered C1 of channel 0
- cx  out  BIT_WIDTH  active pixel index within line
- cy  out  BIT_HEIGHT  active line index within frame
- locked  out  1  raster matches geometry for LOCK_FRAMES frames
- token_err  out  1  one-cycle pulse on channel classification mismatch

## Operation
- Control tokens (C1C0): 00 = 10'b1101010100, 01 = 10'b0010101011, 10 = 10'b0101010100, 11 = 10'b1010101011.
- Classification: a channel word is control if it equals one of the four tokens, otherwise data. de_in = channel 0 is data.
- token_err conditions: channel 0 is control while channel 1 or 2 is not the 00 token; or channel 0 is data while channel 1 or 2 is control. On error, de/hsync/vsync follow channel 0.
- Data decode per channel: d = q[9] ? ~q[7:0] : q[7:0]; out[0] = d[0]; for i = 1..7, out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- hsync/vsync update only on control words; they hold through data words.
- Coordinates: cx = 0 on the first data word of a line, +1 per data word, held while de=0. cy = 0 on the first active line after a vsync falling edge, +1 on each subsequent DE rising edge, held otherwise.
- Lock FSM, states SEARCH, CHECK, LOCKED; good counter 0..LOCK_FRAMES.
  - SEARCH: locked=0, good=0; vsync falling edge -> CHECK, with line/run counters cleared.
  - CHECK/LOCKED per-line checks: DE-high run length == SCREEN_WIDTH; DE-rise-to-DE-rise period == FRAME_WIDTH, except the first line after vsync.
  - CHECK/LOCKED per-frame check, at vsync falling edge: active line count == SCREEN_HEIGHT. On pass, good+1 (saturating); in CHECK, good == LOCK_FRAMES -> LOCKED.
  - Any check failure or token_err in CHECK or LOCKED -> SEARCH.
- Internal run and period counters saturate at all-ones; no wrap.

## Timing
- Stage 1 registers the raw words. Stage 2 registers the decoded and classified results into the outputs.
- Latency: exactly 2 clk_pixel cycles from input words to rgb/de/hsync/vsync/cx/cy/token_err.
- locked falls in the same output cycle that presents the offending word, or the DE edge / vsync edge that exposes the failure. locked rises in the output cycle of the qualifying vsync falling edge.
- Asynchronous reset: rgb=0, de=0, hsync=0, vsync=0, cx=0, cy=0, locked=0, token_err=0, FSM=SEARCH, all counters 0, pipeline cleared.
- Reset mid-frame: outputs return to reset values immediately. After release, output is invalid for 2 cycles and locking restarts from SEARCH.
- Simultaneous vsync falling edge and line-check failure: failure wins; go to SEARCH, no good increment.

## Test plan
- Reset: assert clk_pixel_resetn=0 asynchronously mid-stream -> all outputs 0 before the next edge; locked=0.
- Decode: tmds0/1/2 = 0x100, 0x3FF, 0x200 -> 2 cycles later rgb=24'h0000FF, de=1.
- Control: all channels 10'b1101010100, then channel 0 = 10'b1010101011 -> de=0, hsync=1, vsync=1 with 2-cycle latency; token_err=0.
- Lock: 3 conforming frames from a 1376x810 token generator with hsync at cx 1072..1119 and vsync at cy 772..774 -> locked rises at the vsync falling edge ending the 2nd checked frame. cx hits 1023 and cy hits 767 on the last active pixel.
- Loss: while locked, shorten one active line to 1023 words -> locked falls at that DE falling edge. It relocks after 2 further good frames.
- token_err: channel 0 = control 00 with channel 2 = 0x100 -> token_err pulses 1 cycle, locked falls, FSM=SEARCH.
